// File: rtl/dmem_sched_pkg.sv
// Shared types and helpers for the data-memory store scheduler.
// The optional DMEM_SCHED_COALESCE_EN build merges same-word stores into the FIFO tail.
package dmem_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } sched_state_e;

  localparam int STRB_W = 4;
  localparam int DATA_W = 32;
  localparam int CMP_W  = 64;

  // Word-granular address compare; callers zero-extend addresses to CMP_W.
  function automatic logic word_match(input logic [CMP_W-1:0] a, input logic [CMP_W-1:0] b);
    return (a >> 2) == (b >> 2);
  endfunction

endpackage

// File: rtl/dmem_store_fifo.sv
// In-order store FIFO: storage, pointers, count and per-entry addresses for hazard compare.
// With DMEM_SCHED_COALESCE_EN an accepted store can be merged into the tail entry.
module dmem_store_fifo
  import dmem_sched_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic                            push,
  input  logic                            pop,
`ifdef DMEM_SCHED_COALESCE_EN
  input  logic                            merge,
  output logic [AW-1:0]                   tail_addr,
`endif
  input  logic [AW-1:0]                   in_addr,
  input  logic [STRB_W-1:0]               in_strb,
  input  logic [DATA_W-1:0]               in_data,
  output logic [AW-1:0]                   head_addr,
  output logic [STRB_W-1:0]               head_strb,
  output logic [DATA_W-1:0]               head_data,
  output logic [$clog2(DEPTH):0]          count,
  output logic [DEPTH-1:0][AW-1:0]        ent_addr,
  output logic [DEPTH-1:0]                ent_valid
);

  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0][AW-1:0]     addr_q, addr_d;
  logic [DEPTH-1:0][STRB_W-1:0] strb_q, strb_d;
  logic [DEPTH-1:0][DATA_W-1:0] data_q, data_d;
  logic [PW-1:0]                wptr_q, wptr_d;
  logic [PW-1:0]                rptr_q, rptr_d;
  logic [PW:0]                  count_q, count_d;
  logic                         alloc;

`ifdef DMEM_SCHED_COALESCE_EN
  logic [PW-1:0] tail_idx;
  assign tail_idx  = wptr_q - PW'(1'b1);
  assign tail_addr = addr_q[tail_idx];
`endif

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    addr_d  = addr_q;
    strb_d  = strb_q;
    data_d  = data_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
`ifdef DMEM_SCHED_COALESCE_EN
    alloc = push && !merge;
    if (merge) begin
      strb_d[tail_idx] = strb_q[tail_idx] | in_strb;
      for (int b = 0; b < STRB_W; b++) begin
        data_d[tail_idx][8*b +: 8] = in_strb[b] ? in_data[8*b +: 8] : data_q[tail_idx][8*b +: 8];
      end
    end else begin
      strb_d = strb_q;
    end
`else
    alloc = push;
`endif
    if (alloc) begin
      addr_d[wptr_q] = in_addr;
      strb_d[wptr_q] = in_strb;
      data_d[wptr_q] = in_data;
      wptr_d         = wptr_q + PW'(1'b1);
    end else begin
      wptr_d = wptr_q;
    end
    if (pop) begin
      rptr_d = rptr_q + PW'(1'b1);
    end else begin
      rptr_d = rptr_q;
    end
    case ({alloc, pop})
      2'b10:   count_d = count_q + (PW+1)'(1'b1);
      2'b01:   count_d = count_q - (PW+1)'(1'b1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      addr_q  <= '{default: '0};
      strb_q  <= '{default: '0};
      data_q  <= '{default: '0};
      wptr_q  <= {PW{1'b0}};
      rptr_q  <= {PW{1'b0}};
      count_q <= {(PW+1){1'b0}};
    end else begin
      addr_q  <= addr_d;
      strb_q  <= strb_d;
      data_q  <= data_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // An entry is live when its distance from the read pointer is below the count.
  always_comb begin
    ent_valid = {DEPTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      ent_valid[i] = ({1'b0, PW'(i) - rptr_q} < count_q);
    end
  end

  assign head_addr = addr_q[rptr_q];
  assign head_strb = strb_q[rptr_q];
  assign head_data = data_q[rptr_q];
  assign count     = count_q;
  assign ent_addr  = addr_q;

endmodule

// File: rtl/dmem_store_sched.sv
// Store scheduler between the core memory stage and the data-memory write port.
// Define DMEM_SCHED_COALESCE_EN to merge same-word stores into the FIFO tail.
module dmem_store_sched
  import dmem_sched_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [AW-1:0]     S_WRADDR,
  input  logic              S_WREN,
  input  logic [3:0]        S_WRSTRB,
  input  logic [31:0]       S_WRDATA,
  output logic              S_FULL,
  input  logic [AW-1:0]     S_RDADDR,
  input  logic              S_RDEN,
  output logic              S_RDHAZARD,
  output logic              EMPTY,
  output logic [AW-1:0]     M_WRADDR,
  output logic              M_WREN,
  output logic [3:0]        M_WRSTRB,
  output logic [31:0]       M_WRDATA,
  input  logic              M_BUSY
);

  localparam int          PW       = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);
  localparam logic [PW:0] ZERO_CNT = {(PW+1){1'b0}};

  sched_state_e             state_q, state_d;
  logic                     m_wren_q, m_wren_d;
  logic [AW-1:0]            m_wraddr_q, m_wraddr_d;
  logic [STRB_W-1:0]        m_wrstrb_q, m_wrstrb_d;
  logic [DATA_W-1:0]        m_wrdata_q, m_wrdata_d;
  logic [AW-1:0]            inflight_addr_q, inflight_addr_d;

  logic                     pop, accept, issue_go, s_full, hazard;
  logic [AW-1:0]            head_addr;
  logic [STRB_W-1:0]        head_strb;
  logic [DATA_W-1:0]        head_data;
  logic [PW:0]              count;
  logic [DEPTH-1:0][AW-1:0] ent_addr;
  logic [DEPTH-1:0]         ent_valid;

  assign issue_go = (state_q == S_IDLE) && (count != ZERO_CNT) && !M_BUSY;

`ifdef DMEM_SCHED_COALESCE_EN
  logic [AW-1:0] tail_addr;
  logic          tail_match;
  // The tail is off limits while it is the entry being captured or popped.
  assign tail_match = (count != ZERO_CNT)
                   && word_match(CMP_W'(tail_addr), CMP_W'(S_WRADDR))
                   && !((count == (PW+1)'(1'b1)) && ((state_q == S_ISSUE) || issue_go));
  assign s_full = (count == FULL_CNT) && !tail_match;
`else
  assign s_full = (count == FULL_CNT);
`endif

  assign accept = S_WREN && !s_full;

  dmem_store_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .push      (accept),
    .pop       (pop),
`ifdef DMEM_SCHED_COALESCE_EN
    .merge     (accept && tail_match),
    .tail_addr (tail_addr),
`endif
    .in_addr   (S_WRADDR),
    .in_strb   (S_WRSTRB),
    .in_data   (S_WRDATA),
    .head_addr (head_addr),
    .head_strb (head_strb),
    .head_data (head_data),
    .count     (count),
    .ent_addr  (ent_addr),
    .ent_valid (ent_valid)
  );

  // Drain FSM: capture the head into the issue registers, pop it, then wait out busy.
  always_comb begin
    state_d         = state_q;
    pop             = 1'b0;
    m_wren_d        = 1'b0;
    m_wraddr_d      = {AW{1'b0}};
    m_wrstrb_d      = {STRB_W{1'b0}};
    m_wrdata_d      = {DATA_W{1'b0}};
    inflight_addr_d = inflight_addr_q;
    case (state_q)
      S_IDLE: begin
        if (issue_go) begin
          state_d         = S_ISSUE;
          m_wren_d        = 1'b1;
          m_wraddr_d      = head_addr;
          m_wrstrb_d      = head_strb;
          m_wrdata_d      = head_data;
          inflight_addr_d = head_addr;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        pop     = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!M_BUSY) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Word-granular match against queued, in-flight and incoming stores.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && word_match(CMP_W'(ent_addr[i]), CMP_W'(S_RDADDR))) begin
        hazard = 1'b1;
      end else begin
        hazard = hazard;
      end
    end
    if ((state_q != S_IDLE) && word_match(CMP_W'(inflight_addr_q), CMP_W'(S_RDADDR))) begin
      hazard = 1'b1;
    end else if (accept && word_match(CMP_W'(S_WRADDR), CMP_W'(S_RDADDR))) begin
      hazard = 1'b1;
    end else begin
      hazard = hazard;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q         <= S_IDLE;
      m_wren_q        <= 1'b0;
      m_wraddr_q      <= {AW{1'b0}};
      m_wrstrb_q      <= {STRB_W{1'b0}};
      m_wrdata_q      <= {DATA_W{1'b0}};
      inflight_addr_q <= {AW{1'b0}};
    end else begin
      state_q         <= state_d;
      m_wren_q        <= m_wren_d;
      m_wraddr_q      <= m_wraddr_d;
      m_wrstrb_q      <= m_wrstrb_d;
      m_wrdata_q      <= m_wrdata_d;
      inflight_addr_q <= inflight_addr_d;
    end
  end

  assign S_FULL     = s_full;
  assign S_RDHAZARD = S_RDEN && hazard;
  assign EMPTY      = (count == ZERO_CNT) && (state_q == S_IDLE);
  assign M_WREN     = m_wren_q;
  assign M_WRADDR   = m_wraddr_q;
  assign M_WRSTRB   = m_wrstrb_q;
  assign M_WRDATA   = m_wrdata_q;

endmodule

// File: doc/dmem_store_sched.md
Name: dmem_store_sched

Overview:
- Store scheduler between the RV32I core's memory stage and the data-memory AXI write unit.
- Buffers core stores in an in-order FIFO so the core does not stall on each AXI write.
- Drains stores one at a time into the data-memory write port, respecting its busy indication.
- Flags loads that hit a pending store word so the core can stall until that store is globally issued.

Parameters:
DEPTH, 4, store FIFO entries; power of two, 2..16
AW, 32, address width

Ports:
CLK  in  1  clock
RST  in  1  reset, synchronous, active-high
S_WRADDR  in  AW  core store byte address
S_WREN  in  1  core store request
S_WRSTRB  in  4  core store byte strobes
S_WRDATA  in  32  core store data
S_FULL  out  1  FIFO full; core must hold store
S_RDADDR  in  AW  core load address
S_RDEN  in  1  core load request
S_RDHAZARD  out  1  load word matches a pending store
EMPTY  out  1  no buffered or in-flight store (fence support)
M_WRADDR  out  AW  store address to data memory
M_WREN  out  1  one-cycle store issue pulse
M_WRSTRB  out  4  store strobes
M_WRDATA  out  32  store data
M_BUSY  in  1  data-memory write unit busy (its LOADING)

Behaviour:
- Reset values:
  - S_FULL=0, EMPTY=1, S_RDHAZARD=0.
  - M_WREN=0; M_WRADDR, M_WRSTRB, M_WRDATA = 0.
  - FIFO pointers and count = 0; FSM = S_IDLE.
- Reset mid-operation: all buffered and in-flight stores are discarded. The data-memory unit shares RST.
- FIFO:
  - Entry = {addr, strb, data}.
  - Write pointer, read pointer: log2(DEPTH) bits, natural wrap. Count: log2(DEPTH)+1 bits.
  - Enqueue when S_WREN && !S_FULL. Enqueue while full is ignored; the core must hold.
  - S_FULL = (count==DEPTH), combinational from registered count. A same-cycle pop does not un-full.
  - Simultaneous push and pop: count unchanged.
- Drain FSM:
  - S_IDLE: if count!=0 && !M_BUSY, go to S_ISSUE.
  - S_ISSUE:
    - Pops the head entry.
    - M_WREN, M_WRADDR, M_WRSTRB, M_WRDATA are registered from the head and valid for exactly this one cycle.
    - Next state: S_WAIT.
  - S_WAIT: stays while M_BUSY=1 and goes to S_IDLE when M_BUSY=0. The first S_WAIT cycle always sees M_BUSY=1 because the data memory asserts busy combinationally on WREN.
  - M_WREN returns to 0 after S_ISSUE. Address, strobe and data return to 0.
  - Issue rate: at most one store every 3 + (AXI AW/W latency) cycles.
- Latency: a store accepted at cycle t into an empty idle scheduler has M_WREN=1 at cycle t+2.
- Hazard (combinational):
  - Asserted when S_RDEN=1 and S_RDADDR[AW-1:2] equals [AW-1:2] of any of:
    - a valid FIFO entry,
    - the in-flight store (S_ISSUE/S_WAIT),
    - an incoming store being accepted this cycle.
  - Byte strobes are ignored; comparison is word-granular.
- EMPTY = (count==0) && state==S_IDLE.

Optional Feature:
DMEM_SCHED_COALESCE_EN
- With macro:
  - An accepted store whose word address equals the tail entry's is merged into the tail instead of allocated.
  - Merge rule: data bytes replaced where S_WRSTRB=1; strobes OR'd.
  - Merge happens only if the tail is not the entry being popped that cycle.
  - Merge is permitted even when S_FULL=1. Full then no longer blocks a matching store, and S_FULL is computed as (count==DEPTH && !tail_match).
- Without macro: every store occupies its own entry; no merging logic.

Decomposition:
- Shared package dmem_sched_pkg: FSM state encodings (S_IDLE, S_ISSUE, S_WAIT), entry field widths, word-address compare helper width.
- One natural sub-module: dmem_store_fifo (storage, pointers, count, per-entry address outputs for hazard compare).
- FSM and hazard logic stay in the top.

Test Plan:
- Single store 0x0000_1004, strb 4'b1111, data 0xDEADBEEF into an idle scheduler:
  - M_WREN pulses once at t+2 with those values.
  - EMPTY returns to 1 after M_BUSY drops.
- Six back-to-back stores with DEPTH=4 and M_BUSY held 1 for 20 cycles:
  - S_FULL rises after 4 accepts.
  - Entries drain in order, one per M_BUSY low window; no drops or duplicates.
- Store to 0x2000 pending, load 0x2002 with S_RDEN=1:
  - S_RDHAZARD=1 until the S_WAIT→S_IDLE exit for that store.
  - Load 0x2004 gives S_RDHAZARD=0.
- RST asserted with 3 entries and one in S_WAIT:
  - Next cycle count=0, EMPTY=1, M_WREN=0, no further M_WREN pulses.
- Coalescing (macro on): stores to 0x3000 strb 4'b0001 data 0x11, then strb 4'b0100 data 0x00220000:
  - One entry; M_WRSTRB=4'b0101, M_WRDATA=0x00220011.
- Coalescing (macro off), same two stores:
  - Two M_WREN pulses with the original strobes.
